// File: rtl/div_seq_32.sv
// Multicycle signed restoring divider: one trial subtraction and shift per cycle,
// with sign fix-up at the end and a divide-by-zero / overflow exception flag.
module div_seq_32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] data_dividend,
  input  logic [WIDTH-1:0] data_divisor,
  output logic [WIDTH-1:0] data_quotient,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_e;

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend magnitude, becomes quotient bits
  logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder
  logic [WIDTH:0]   dsr_q, dsr_d;     // divisor magnitude
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             exc_q, exc_d;

  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH:0]   dsr_ext, dsr_mag;
  logic [WIDTH:0]   rem_shift, trial;
  logic             div_zero, div_ovf;

  assign dvd_mag   = data_dividend[WIDTH-1] ? -data_dividend : data_dividend;
  assign dsr_ext   = {data_divisor[WIDTH-1], data_divisor};
  assign dsr_mag   = dsr_ext[WIDTH] ? -dsr_ext : dsr_ext;
  assign div_zero  = (data_divisor == '0);
  assign div_ovf   = (data_dividend == MIN_VAL) && (data_divisor == '1);

  // Shift the next dividend bit into the partial remainder, then subtract in a+~b+1 form;
  // the top bit of the WIDTH+1 result says whether to restore.
  assign rem_shift = {rem_q, dvd_q[WIDTH-1]};
  assign trial     = rem_shift + ~dsr_q + (WIDTH+1)'(1);

  // NOTE: every always_comb output is given its hold value first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    dsr_d   = dsr_q;
    cnt_d   = cnt_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    exc_d   = exc_q;

    unique case (state_q)
      IDLE: begin
        if (ctrl_div) begin
          exc_d   = 1'b0;
          dvd_d   = dvd_mag;
          dsr_d   = dsr_mag;
          rem_d   = '0;
          cnt_d   = '0;
          q_neg_d = data_dividend[WIDTH-1] ^ data_divisor[WIDTH-1];
          r_neg_d = data_dividend[WIDTH-1];
          if (div_zero) begin
            exc_d   = 1'b1;
            quot_d  = '0;
            remo_d  = '0;
            state_d = DONE;
          end else if (div_ovf) begin
            exc_d   = 1'b1;
            quot_d  = MIN_VAL;
            remo_d  = '0;
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d = trial[WIDTH] ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
        dvd_d = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) state_d = FIX;
      end
      FIX: begin
        quot_d  = q_neg_q ? -dvd_q : dvd_q;
        remo_d  = r_neg_q ? -rem_q : rem_q;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      rem_q   <= '0;
      dsr_q   <= '0;
      cnt_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      dsr_q   <= dsr_d;
      cnt_q   <= cnt_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      exc_q   <= exc_d;
    end
  end

  assign data_quotient  = quot_q;
  assign data_remainder = remo_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == DONE);
  assign busy           = (state_q == RUN) || (state_q == FIX);

endmodule

// File: doc/div_seq_32.md
Name: div_seq_32

Overview:
- Multicycle signed restoring divider, WIDTH-bit; the division counterpart to the team's carry-lookahead adder.
- Sits beside the ALU in the execute stage and serves div instructions.
- Each iteration performs one trial subtraction (adder in a-plus-not-b-plus-1 form) plus one shift.
- Outputs quotient and remainder, with a divide-by-zero/overflow exception flag.

Parameters:
- WIDTH, 32, operand and result width in bits. Only 32 is verified.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ctrl_div  in  1  start strobe. Sampled only in IDLE.
- data_dividend  in  WIDTH  signed dividend. Sampled on the start edge.
- data_divisor  in  WIDTH  signed divisor. Sampled on the start edge.
- data_quotient  out  WIDTH  signed quotient, truncated toward zero.
- data_remainder  out  WIDTH  signed remainder; its sign follows the dividend.
- data_exception  out  1  divide-by-zero or overflow flag.
- data_resultRDY  out  1  one-cycle pulse when results are valid.
- busy  out  1  high from the start edge until the cycle data_resultRDY is asserted.

Behaviour:
- Reset (reset_n low, asynchronous): state goes to IDLE. All outputs, the counter and internal registers go to 0. Takes effect immediately, including mid-division; the in-flight operation is discarded and no data_resultRDY is produced for it.
- States: IDLE, RUN, FIX, DONE.
- IDLE, ctrl_div=1 at edge E0:
  - Latch the operands.
  - Compute magnitudes and the result signs: quotient sign = XOR of the operand sign bits; remainder sign = dividend sign.
  - Clear the partial remainder; count=0; busy=1.
- IDLE to DONE at E0 (zero divisor): if divisor==0, set exception=1 and quotient=remainder=0.
- IDLE to DONE at E0 (overflow): if dividend==0x80000000 and divisor==0xFFFFFFFF, set exception=1, quotient=0x80000000, remainder=0.
- Otherwise IDLE goes to RUN at E0.
- RUN, one step per edge:
  - Shift {partial remainder, dividend register} left by 1.
  - Trial-subtract the divisor magnitude from the partial remainder.
  - If the result is non-negative, keep it and set quotient LSB=1; else restore and set LSB=0.
  - count increments.
  - After WIDTH steps (edges E1..E32), go to FIX.
- FIX (edge E33): negate the quotient and/or remainder per the latched signs, register them to the outputs, go to DONE.
- DONE (one cycle):
  - data_resultRDY=1, busy=0.
  - Next edge: IDLE, data_resultRDY=0.
- Latency: data_resultRDY is high in the cycle after E33 for the normal path, and in the cycle after E0 for the exception path.
- Output hold: data_quotient, data_remainder and data_exception hold their values until the next accepted start, which clears data_exception at its E0.
- ctrl_div outside IDLE (RUN/FIX/DONE) is ignored, with no queuing. It is accepted again only once the state is IDLE.
- ctrl_div held high continuously starts a new operation on each visit to IDLE, i.e. back-to-back with a one-cycle IDLE gap.
- Operand inputs may change freely after E0.
- Arithmetic:
  - Magnitudes are WIDTH+1 bits internally, so abs(0x80000000) is represented correctly.
  - The trial subtraction is WIDTH+1 bits wide; the sign bit of that result selects restore.
  - Negation is two's complement.

Test Plan:
- 100 / 7 → after 34 cycles (RDY in the cycle after E33), quotient=14, remainder=2, exception=0; busy high E0..E33.
- -100 / 7 → quotient=-14 (0xFFFFFFF2), remainder=-2 (0xFFFFFFFE).
- 100 / -7 → quotient=-14, remainder=2.
- 0x80000000 / 2 → quotient=0xC0000000, remainder=0.
- 55 / 0 → data_resultRDY pulses in the cycle after E0, exception=1, quotient=0, remainder=0.
- 0x80000000 / -1 → exception=1, quotient=0x80000000.
- Reset mid-RUN: start 1000/3, drop reset_n at the 10th RUN cycle. Outputs clear asynchronously and no RDY pulse follows.
- Restart 9/3 after reset → quotient=3, remainder=0.
- Start strobes during RUN: ignored; the first result is still correct and exactly one RDY pulse is produced.
